adc_frame_capturer: RTL

ADC_FRAME_CAPTURER -- requirements
Module: adc_frame_capturer

---
 rtl/adc_capture_pkg.sv | 18 +
 rtl/sample_frame_ram.sv | 25 ++
 rtl/adc_frame_capturer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC frame capturer: FSM states, UART command bytes
// and the frame sync marker.
package adc_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_HEADER,
        ST_DUMP,
        ST_TRAILER
    } cap_state_t;

    localparam logic [7:0] C_CMD_SINGLE = 8'd110;  // 'n'
    localparam logic [7:0] C_CMD_CONT   = 8'd99;   // 'c'
    localparam logic [7:0] C_CMD_ABORT  = 8'd120;  // 'x'
    localparam logic [7:0] C_SYNC_BYTE  = 8'hA5;

endpackage

// File: rtl/sample_frame_ram.sv
// Simple dual-port sample buffer, one write port and one registered read port,
// written so synthesis maps it onto block RAM.
module sample_frame_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              CLOCK,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge CLOCK) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_frame_capturer.sv
// Captures a frame of ADC samples into a buffer on a UART command, then streams
// it out as SYNC, little-endian 16-bit samples and an XOR checksum byte.
module adc_frame_capturer
    import adc_capture_pkg::*;
#(
    parameter int         SAMPLE_WIDTH = 14,
    parameter int         DEPTH_LOG2   = 11,
    parameter logic [7:0] CMD_SINGLE   = C_CMD_SINGLE,
    parameter logic [7:0] CMD_CONT     = C_CMD_CONT,
    parameter logic [7:0] CMD_ABORT    = C_CMD_ABORT,
    parameter logic [7:0] SYNC_BYTE    = C_SYNC_BYTE
) (
    input  logic                    CLOCK,
    input  logic                    rst,
    input  logic [7:0]              cmd_tdata,
    input  logic                    cmd_tvalid,
    output logic                    cmd_tready,
    input  logic [SAMPLE_WIDTH-1:0] smp_tdata,
    input  logic                    smp_tvalid,
    output logic                    adc_enable,
    output logic [7:0]              tx_tdata,
    output logic                    tx_tvalid,
    input  logic                    tx_tready,
    output logic                    busy,
    output logic [15:0]             frame_count
);
    localparam int N = 1 << DEPTH_LOG2;

    cap_state_t            r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2:0]   r_rptr;
    logic                  r_phase;
    logic [7:0]            r_hi, r_csum, r_tx_tdata;
    logic                  r_cont, r_abort, r_adc_en, r_tx_tvalid;
    logic [15:0]           r_frame_cnt;

    logic [15:0] w_rd_data;
    logic        w_wr, w_last_wr, w_tx_free;
    logic        w_cmd_single, w_cmd_cont, w_cmd_abort;
    logic        w_tx_ld, w_tx_clr, w_lo_ld, w_hi_ld, w_fc_inc;
    logic        w_cont_nxt, w_abort_nxt;
    logic [7:0]  w_tx_byte;

    assign w_cmd_single = cmd_tvalid && (cmd_tdata == CMD_SINGLE);
    assign w_cmd_cont   = cmd_tvalid && (cmd_tdata == CMD_CONT);
    assign w_cmd_abort  = cmd_tvalid && (cmd_tdata == CMD_ABORT);
    assign w_wr         = (r_state == ST_CAPTURE) && smp_tvalid;
    assign w_last_wr    = w_wr && (r_wptr == DEPTH_LOG2'(N - 1));
    assign w_tx_free    = !r_tx_tvalid || tx_tready;

    sample_frame_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (16)
    ) u_ram (
        .CLOCK   (CLOCK),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (16'(smp_tdata)),
        .i_raddr (r_rptr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge CLOCK) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cont_nxt  = r_cont;
        w_abort_nxt = r_abort;
        w_tx_ld     = 1'b0;
        w_tx_byte   = '0;
        w_tx_clr    = 1'b0;
        w_lo_ld     = 1'b0;
        w_hi_ld     = 1'b0;
        w_fc_inc    = 1'b0;
        if (r_state != ST_IDLE && w_cmd_single)
            w_cont_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd_single) begin
                    w_state_nxt = ST_CAPTURE;
                    w_cont_nxt  = 1'b0;
                end else if (w_cmd_cont) begin
                    w_state_nxt = ST_CAPTURE;
                    w_cont_nxt  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // A command landing on the final write is handled as if already in HEADER.
                if (w_last_wr) begin
                    w_state_nxt = ST_HEADER;
                    if (w_cmd_abort) begin
                        w_abort_nxt = 1'b1;
                        w_cont_nxt  = 1'b0;
                    end
                end else if (w_cmd_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cont_nxt  = 1'b0;
                end
            end
            default: begin
                if (w_cmd_abort) begin
                    w_abort_nxt = 1'b1;
                    w_cont_nxt  = 1'b0;
                end
                if (w_tx_free) begin
                    if (w_abort_nxt) begin
                        w_state_nxt = ST_IDLE;
                        w_tx_clr    = 1'b1;
                    end else if (r_state == ST_HEADER) begin
                        w_tx_ld = 1'b1;
                        if (!r_tx_tvalid) begin
                            w_tx_byte = SYNC_BYTE;
                        end else begin
                            w_tx_byte   = w_rd_data[7:0];
                            w_lo_ld     = 1'b1;
                            w_state_nxt = ST_DUMP;
                        end
                    end else if (r_state == ST_DUMP) begin
                        w_tx_ld = 1'b1;
                        if (r_phase) begin
                            w_tx_byte = r_hi;
                            w_hi_ld   = 1'b1;
                        end else if (r_rptr == (DEPTH_LOG2 + 1)'(N)) begin
                            w_tx_byte   = r_csum;
                            w_state_nxt = ST_TRAILER;
                        end else begin
                            w_tx_byte = w_rd_data[7:0];
                            w_lo_ld   = 1'b1;
                        end
                    end else begin
                        w_fc_inc    = 1'b1;
                        w_tx_clr    = 1'b1;
                        w_state_nxt = w_cont_nxt ? ST_CAPTURE : ST_IDLE;
                    end
                end
            end
        endcase
    end

    // The read pointer advances on each low byte, so the next sample is already
    // on the RAM output by the time its low byte is due.
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_phase     <= 1'b0;
            r_hi        <= '0;
            r_csum      <= '0;
            r_cont      <= 1'b0;
            r_abort     <= 1'b0;
            r_adc_en    <= 1'b0;
            r_tx_tdata  <= '0;
            r_tx_tvalid <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_adc_en <= (w_state_nxt == ST_CAPTURE);
            r_cont   <= w_cont_nxt;
            r_abort  <= (w_state_nxt == ST_IDLE) ? 1'b0 : w_abort_nxt;
            if (r_state != ST_CAPTURE)
                r_wptr <= '0;
            else if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (r_state == ST_CAPTURE) begin
                r_rptr  <= '0;
                r_phase <= 1'b0;
                r_csum  <= '0;
            end else begin
                if (w_lo_ld) begin
                    r_rptr  <= r_rptr + 1'b1;
                    r_hi    <= w_rd_data[15:8];
                    r_phase <= 1'b1;
                end else if (w_hi_ld) begin
                    r_phase <= 1'b0;
                end
                if (w_lo_ld || w_hi_ld)
                    r_csum <= r_csum ^ w_tx_byte;
            end
            if (w_tx_ld) begin
                r_tx_tvalid <= 1'b1;
                r_tx_tdata  <= w_tx_byte;
            end else if (w_tx_clr || tx_tready) begin
                r_tx_tvalid <= 1'b0;
            end
            if (w_fc_inc)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign cmd_tready  = 1'b1;
    assign adc_enable  = r_adc_en;
    assign tx_tdata    = r_tx_tdata;
    assign tx_tvalid   = r_tx_tvalid;
    assign busy        = (r_state != ST_IDLE);
    assign frame_count = r_frame_cnt;

endmodule
